// File: rtl/obi_mem_dumper.sv
// OBI read initiator that fetches num_words consecutive words from base_addr and
// streams them out in order through a small response FIFO.
module obi_mem_dumper #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [10:0] num_words,
    output logic        busy,
    output logic        done,
    output logic        err_unexp,
    output logic        obi_req,
    input  logic        obi_gnt,
    output logic [31:0] obi_addr,
    output logic        obi_we,
    output logic [3:0]  obi_be,
    output logic [31:0] obi_wdata,
    input  logic        obi_rvalid,
    input  logic [31:0] obi_rdata,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [31:0] dout_data,
    output logic [9:0]  dout_index,
    output logic        dout_last
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW:0]   DEPTH_W = (OW+1)'(FIFO_DEPTH);
    localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [10:0]   num_q;
    logic [10:0]   issued;
    logic [10:0]   popped;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] fifo_count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [OW:0]   credit_used;

    logic start_acc;
    logic gnt_fire;
    logic last_grant;
    logic rsp_ok;
    logic rsp_unexp;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;

    assign start_acc   = start && (state == IDLE);
    // Outstanding requests plus buffered words never exceed the FIFO, so every
    // response already owns a slot when it arrives.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign obi_req     = (state == REQ) && (issued < num_q) && (credit_used < DEPTH_W);
    assign gnt_fire    = obi_req && obi_gnt;
    assign last_grant  = gnt_fire && (issued == num_q - 11'd1);

    assign rsp_ok      = obi_rvalid && (outstanding != '0);
    assign rsp_unexp   = obi_rvalid && (outstanding == '0);
    assign fifo_push   = rsp_ok;
    assign fifo_full   = (fifo_count == DEPTH_C);

    assign dout_valid  = (fifo_count != '0);
    assign fifo_pop    = dout_valid && dout_ready;
    assign dout_data   = dout_valid ? mem[rd_ptr] : '0;
    assign dout_index  = popped[9:0];
    assign dout_last   = dout_valid && (popped == num_q - 11'd1);

    assign obi_we      = 1'b0;
    assign obi_be      = 4'hF;
    assign obi_wdata   = '0;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (num_words != '0) ? REQ : DONE;
                end
            end
            REQ: begin
                if (last_grant) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_pop && dout_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            num_q       <= '0;
            issued      <= '0;
            popped      <= '0;
            obi_addr    <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err_unexp   <= 1'b0;
        end else begin
            if (start_acc && (num_words != '0)) begin
                num_q    <= num_words;
                issued   <= '0;
                popped   <= '0;
                obi_addr <= base_addr & 32'hFFFF_FFFC;
            end else begin
                if (gnt_fire) begin
                    obi_addr <= obi_addr + 32'd4;
                    issued   <= issued + 11'd1;
                end
                if (fifo_pop) begin
                    popped <= popped + 11'd1;
                end
            end

            outstanding <= outstanding + OW'(gnt_fire) - OW'(rsp_ok);
            fifo_count  <= fifo_count + OW'(fifo_push) - OW'(fifo_pop);
            if (fifo_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            // A stray response in the same cycle as a start still gets flagged.
            if (start_acc) begin
                err_unexp <= 1'b0;
            end
            if (rsp_unexp) begin
                err_unexp <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fifo_push) begin
            mem[wr_ptr] <= obi_rdata;
        end
    end

    a_no_push_on_full: assert property (@(posedge CLK) disable iff (!RSTn)
        !(fifo_push && fifo_full));

endmodule

// File: tb/tb_obi_mem_dumper.sv
// Randomized scoreboard bench for obi_mem_dumper: an OBI slave model, a stream
// sink, and a monitor that checks every grant and output word against queues.
module tb_obi_mem_dumper;
    localparam int FIFO_DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        start;
    logic [31:0] base_addr;
    logic [10:0] num_words;
    logic        busy;
    logic        done;
    logic        err_unexp;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic [9:0]  dout_index;
    logic        dout_last;

    obi_mem_dumper #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK(CLK), .RSTn(RSTn), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .err_unexp(err_unexp),
        .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr),
        .obi_we(obi_we), .obi_be(obi_be), .obi_wdata(obi_wdata),
        .obi_rvalid(obi_rvalid), .obi_rdata(obi_rdata),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_index(dout_index), .dout_last(dout_last)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] data;
        logic [9:0]  idx;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] rsp_q[$];

    int n_checks, n_fail;
    int gnt_prob, rsp_prob, ready_prob, gnt_limit, slv_grants;
    logic [31:0] hold_addr;
    int hold_left;
    int done_seen, req_cycles, stall_cnt, g_cnt, p_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic bit chance(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    task automatic slave_loop();
        forever begin
            @(posedge CLK); #1;
            obi_rvalid = 1'b0;
            obi_rdata  = $urandom;
            if (rsp_q.size() != 0 && chance(rsp_prob)) begin
                obi_rvalid = 1'b1;
                obi_rdata  = rsp_q.pop_front();
            end
            obi_gnt = 1'b0;
            if (obi_req && slv_grants < gnt_limit) begin
                if (hold_left > 0 && obi_addr == hold_addr) begin
                    hold_left--;
                end else if (chance(gnt_prob)) begin
                    obi_gnt = 1'b1;
                    rsp_q.push_back(mem_word(obi_addr));
                    slv_grants++;
                end
            end
        end
    endtask

    task automatic sink_loop();
        forever begin
            @(posedge CLK); #1;
            dout_ready = chance(ready_prob);
        end
    endtask

    task automatic monitor_loop();
        bit          req_wait, out_wait;
        logic [31:0] p_addr, p_data;
        logic [9:0]  p_idx;
        logic        p_last;
        word_t       w;
        req_wait = 0;
        out_wait = 0;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                addr_q.delete();
                exp_q.delete();
                req_wait = 0;
                out_wait = 0;
            end else begin
                if (start && !busy) begin
                    g_cnt = 0;
                    p_cnt = 0;
                end
                if (req_wait) begin
                    chk("req_hold", obi_req, 1);
                    chk("addr_hold", obi_addr, p_addr);
                end
                if (out_wait) begin
                    chk("dout_valid_hold", dout_valid, 1);
                    chk("dout_data_hold", dout_data, p_data);
                    chk("dout_index_hold", dout_index, p_idx);
                    chk("dout_last_hold", dout_last, p_last);
                end
                if (obi_req && obi_gnt) begin
                    chk("credit", (g_cnt - p_cnt) < FIFO_DEPTH, 1);
                    if (addr_q.size() == 0) fail_now("grant_extra");
                    else chk("grant_addr", obi_addr, addr_q.pop_front());
                    g_cnt++;
                end
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("dout_extra");
                    end else begin
                        w = exp_q.pop_front();
                        chk("dout_data", dout_data, w.data);
                        chk("dout_index", dout_index, w.idx);
                        chk("dout_last", dout_last, w.last);
                    end
                    p_cnt++;
                end
                if (done) begin
                    done_seen++;
                    chk("done_busy", busy, 1);
                end
                if (obi_req) req_cycles++;
                if (obi_req && !obi_gnt && obi_addr == hold_addr) stall_cnt++;
                req_wait = obi_req && !obi_gnt;
                p_addr   = obi_addr;
                out_wait = dout_valid && !dout_ready;
                p_data   = dout_data;
                p_idx    = dout_index;
                p_last   = dout_last;
            end
        end
    endtask

    task automatic expect_dump(input logic [31:0] base, input int n);
        logic [31:0] a;
        word_t w;
        for (int i = 0; i < n; i++) begin
            a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
            addr_q.push_back(a);
            w.data = mem_word(a);
            w.idx  = 10'(i);
            w.last = (i == n - 1);
            exp_q.push_back(w);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_obi_req", obi_req, 0);
        chk("rst_obi_addr", obi_addr, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_data", dout_data, 0);
        chk("rst_dout_index", dout_index, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    task automatic run_dump(input logic [31:0] base, input int n,
                            input int ready_hold, input bit poke_start);
        int d0, g0, r0;
        bit fin;
        expect_dump(base, n);
        d0 = done_seen;
        g0 = slv_grants;
        r0 = req_cycles;
        @(posedge CLK); #1;
        start = 1'b1;
        base_addr = base;
        num_words = 11'(n);
        @(posedge CLK); #1;
        start = 1'b0;
        base_addr = $urandom;
        num_words = 11'($urandom);
        chk("busy_after_start", busy, 1);
        chk("err_cleared", err_unexp, 0);
        if (n == 0) begin
            chk("zero_done", done, 1);
            chk("zero_req", obi_req, 0);
        end else begin
            chk("first_req", obi_req, 1);
        end
        fin = 0;
        for (int it = 1; it <= 20000 && !fin; it++) begin
            if (poke_start && it == 3) begin
                chk("poke_busy", busy, 1);
                start = 1'b1;
                base_addr = 32'h0000_8000;
                num_words = 11'd7;
            end
            if (poke_start && it == 4) start = 1'b0;
            if (ready_hold != 0 && it == ready_hold) begin
                chk("credit_fill", 32'(slv_grants - g0), 32'(n < FIFO_DEPTH ? n : FIFO_DEPTH));
                ready_prob = 100;
            end
            @(posedge CLK); #1;
            if (done_seen != d0) fin = 1;
        end
        if (!fin) fail_now("done_timeout");
        @(posedge CLK); #1;
        chk("idle_after_done", busy, 0);
        chk("done_once", 32'(done_seen - d0), 1);
        chk("addr_q_empty", addr_q.size(), 0);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("err_clean", err_unexp, 0);
        if (n == 0) chk("zero_no_req", 32'(req_cycles - r0), 0);
    endtask

    task automatic set_probs(input int g, input int r, input int d);
        gnt_prob   = g;
        rsp_prob   = r;
        ready_prob = d;
    endtask

    initial begin
        int g0, d0, s0, n;
        n_checks = 0; n_fail = 0;
        slv_grants = 0; gnt_limit = 32'h7FFF_FFFF;
        hold_addr = 32'hFFFF_FFF0; hold_left = 0;
        done_seen = 0; req_cycles = 0; stall_cnt = 0; g_cnt = 0; p_cnt = 0;
        set_probs(100, 100, 100);
        RSTn = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0; dout_ready = 1'b0;
        fork
            slave_loop();
            sink_loop();
            monitor_loop();
        join_none

        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs();
        chk("rst_err", err_unexp, 0);
        chk("const_we", obi_we, 0);
        chk("const_be", obi_be, 32'hF);
        chk("const_wdata", obi_wdata, 0);
        RSTn = 1'b1;

        // Basic dump with immediate grants and responses.
        set_probs(100, 100, 100);
        run_dump(32'h0000_0100, 4, 0, 0);

        // Stalled sink: FIFO credit caps outstanding grants.
        set_probs(100, 100, 0);
        run_dump(32'h0000_0200, 8, 20, 0);

        // Grant withheld on the second request.
        set_probs(100, 100, 100);
        hold_addr = 32'h0000_0304;
        hold_left = 5;
        s0 = stall_cnt;
        run_dump(32'h0000_0300, 4, 0, 0);
        chk("hold_stall", 32'(stall_cnt - s0), 5);
        hold_addr = 32'hFFFF_FFF0;

        // Zero-length dump, then a start while busy.
        run_dump(32'h0000_0400, 0, 0, 0);
        set_probs(70, 70, 70);
        run_dump(32'h0000_0500, 5, 0, 1);

        // Address wrap-around and unaligned base.
        set_probs(100, 100, 100);
        run_dump(32'hFFFF_FFFC, 2, 0, 0);
        run_dump(32'h0000_0A03, 3, 0, 0);

        for (int k = 0; k < 10; k++) begin
            set_probs(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                      int'($urandom_range(30, 100)));
            n = int'($urandom_range(1, 40));
            run_dump($urandom, n, 0, 0);
        end

        set_probs(80, 80, 80);
        run_dump($urandom, 1024, 0, 0);

        // Reset mid-dump after two grants; late responses must flag err_unexp.
        set_probs(100, 0, 100);
        g0 = slv_grants;
        gnt_limit = g0 + 2;
        expect_dump(32'h0000_2000, 6);
        @(posedge CLK); #1;
        start = 1'b1; base_addr = 32'h0000_2000; num_words = 11'd6;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int it = 0; it < 50 && slv_grants < g0 + 2; it++) begin
            @(posedge CLK); #1;
        end
        chk("rst_two_grants", 32'(slv_grants - g0), 2);
        repeat (2) begin
            @(posedge CLK); #1;
        end
        d0 = done_seen;
        RSTn = 1'b0;
        @(posedge CLK); #1;
        check_reset_outputs();
        chk("rst_mid_err", err_unexp, 0);
        RSTn = 1'b1;
        rsp_prob = 100;
        gnt_limit = 32'h7FFF_FFFF;
        repeat (8) begin
            @(posedge CLK); #1;
        end
        chk("late_rsp_err", err_unexp, 1);
        chk("late_rsp_no_dout", dout_valid, 0);
        chk("late_rsp_idle", busy, 0);
        chk("late_rsp_no_req", obi_req, 0);
        chk("late_rsp_no_done", 32'(done_seen - d0), 0);
        chk("late_rsp_drained", rsp_q.size(), 0);

        // A new accepted start clears the sticky error.
        set_probs(90, 90, 90);
        run_dump(32'h0000_3000, 3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/obi_mem_dumper.md
OBI_MEM_DUMPER -- requirements
Module: obi_mem_dumper

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, response buffer depth in words (power of two, >=2).
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 RSTn  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  one-cycle request to begin a dump; ignored while busy=1.
REQ-005 base_addr  in  32  byte address of first word, sampled with start; bits [1:0] treated as 0.
REQ-006 num_words  in  11  words to read (0..1024), sampled with start.
REQ-007 busy  out  1  high from cycle after accepted start until done pulse inclusive.
REQ-008 done  out  1  one-cycle pulse at end of dump.
REQ-009 err_unexp  out  1  sticky flag: rvalid received with zero outstanding requests; cleared only by reset or accepted start.
REQ-010 obi_req / obi_gnt  out / in  1 / 1  OBI address-phase handshake (initiator side).
REQ-011 obi_addr  out  32  word-aligned byte address.
REQ-012 obi_we, obi_be, obi_wdata  out  1, 4, 32  constant 0, 4'hF, 32'h0 (reads only).
REQ-013 obi_rvalid / obi_rdata  in  1 / 32  OBI response phase.
REQ-014 dout_valid / dout_ready  out / in  1 / 1  output stream handshake; transfer when both high.
REQ-015 dout_data  out  32  read word; dout_index  out  10  word index (0-based); dout_last  out  1  high on final word.

Function
REQ-016 FSM states IDLE, REQ, DRAIN, DONE; IDLE after reset.
REQ-017 IDLE: start with num_words!=0 -> latch base_addr/num_words, clear err_unexp, go REQ; start with num_words==0 -> go DONE, no OBI traffic.
REQ-018 REQ: obi_req high when issued<num_words and (outstanding + fifo_count) < FIFO_DEPTH; first obi_req visible the cycle after start.
REQ-019 Once obi_req is high, obi_req and obi_addr SHALL stay stable until obi_gnt; obi_req never drops without a grant.
REQ-020 On req&&gnt: obi_addr += 4 (mod 2^32), issued++, outstanding++; back-to-back grants allowed (one address per cycle).
REQ-021 REQ -> DRAIN on the cycle the last grant is accepted (issued reaches num_words).
REQ-022 On obi_rvalid with outstanding>0: push obi_rdata into FIFO, outstanding--; responses in issue order.
REQ-023 Credit rule of REQ-018 guarantees no push into a full FIFO; a push on full is a design error (assertion).
REQ-024 No bypass: rvalid in cycle t -> dout_valid earliest cycle t+1; FIFO push and pop in same cycle allowed at any occupancy.
REQ-025 dout_data/index/last stable while dout_valid=1 and dout_ready=0.
REQ-026 dout_last=1 exactly when dout_index==num_words-1.
REQ-027 DRAIN -> DONE on the cycle the last word is popped (dout_valid&&dout_ready&&dout_last).
REQ-028 DONE: done=1 for exactly one cycle, busy=1 that cycle, then IDLE.
REQ-029 obi_rvalid with outstanding==0 (any state): data dropped, err_unexp set.
REQ-030 Counters: issued/received 11 bits, outstanding width log2(FIFO_DEPTH)+1; num_words=1024 SHALL complete without overflow.

Reset
REQ-031 RSTn=0 at a rising edge: state IDLE; obi_req=0, obi_addr=0, dout_valid=0, dout_data=0, dout_index=0, dout_last=0, busy=0, done=0, err_unexp=0; FIFO and all counters cleared.
REQ-032 Reset mid-dump aborts immediately; no done pulse; responses for pre-reset requests arriving after reset set err_unexp.

Verification
REQ-033 base_addr=0x100, num_words=4, gnt and rvalid one cycle after req, dout_ready=1 -> addrs 0x100,0x104,0x108,0x10C; 4 words index 0..3, last on index 3, done pulse once.
REQ-034 num_words=8, dout_ready=0 for 20 cycles then 1 -> at most FIFO_DEPTH=4 grants before first pop; no data lost; all 8 words in order.
REQ-035 gnt withheld 5 cycles on 2nd request -> obi_req and obi_addr=base+4 constant for all 5 cycles.
REQ-036 start with num_words=0 -> no obi_req, done pulse 1 cycle after start; start asserted while busy -> ignored, latched values unchanged.
REQ-037 base_addr=0xFFFFFFFC, num_words=2 -> addrs 0xFFFFFFFC then 0x00000000.
REQ-038 RSTn low after 2 grants of a 6-word dump, then rvalid pulse -> all outputs at reset values, err_unexp=1, no done.
